// File: rtl/rw_axi4_bridge_pkg.sv
// Shared AXI encodings and bridge state type for the rw-to-AXI4 bridge.
// Imported by the bridge top and its alignment helper.
package rw_axi4_bridge_pkg;

    localparam logic [2:0] AXI_SIZE_BYTES_1 = 3'd0;
    localparam logic [2:0] AXI_SIZE_BYTES_2 = 3'd1;
    localparam logic [2:0] AXI_SIZE_BYTES_4 = 3'd2;
    localparam logic [2:0] AXI_SIZE_BYTES_8 = 3'd3;

    localparam logic [1:0] AXI_BURST_TYPE_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_TYPE_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_TYPE_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } bridge_state_t;

    function automatic logic is_err_resp(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/rw_axi4_bridge_align.sv
// Byte-lane alignment for narrow accesses: write strobe and data shifts.
// Bursts use full-width lanes with no shift.
module rw_axi4_align
    import rw_axi4_bridge_pkg::*;
(
    input  logic [2:0] i_off,
    input  logic [2:0] i_size,
    input  logic       i_burst,
    output logic [7:0] o_wstrb,
    output logic [5:0] o_wshift,
    output logic [5:0] o_rshift
);

    logic [7:0] w_mask;
    logic [5:0] w_shift;

    always_comb begin
        w_mask = 8'hff;
        unique case (i_size)
            AXI_SIZE_BYTES_1: w_mask = 8'h01;
            AXI_SIZE_BYTES_2: w_mask = 8'h03;
            AXI_SIZE_BYTES_4: w_mask = 8'h0f;
            default:          w_mask = 8'hff;
        endcase
    end

    // Lanes pushed past byte 7 by a misaligned offset are dropped.
    assign w_shift  = i_burst ? 6'd0 : {i_off, 3'b000};
    assign o_wstrb  = i_burst ? 8'hff : (w_mask << i_off);
    assign o_wshift = w_shift;
    assign o_rshift = w_shift;

endmodule

// File: rtl/rw_axi4_bridge.sv
// rw master interface to AXI4 master bridge, one transaction in flight.
// Address channels registered; data beats pass through combinationally.
module rw_axi4_bridge
    import rw_axi4_bridge_pkg::*;
#(
    parameter int RW_DATA_WIDTH = 64,
    parameter int RW_ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rw_addr_valid_i,
    output logic                     rw_addr_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] rw_addr_i,
    input  logic                     rw_we_i,
    input  logic [7:0]               rw_len_i,
    input  logic [2:0]               rw_size_i,
    input  logic [1:0]               rw_burst_i,
    input  logic                     rw_if_i,
    input  logic                     w_data_valid_i,
    output logic                     w_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] w_data_i,
    output logic                     r_data_valid_o,
    input  logic                     r_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] r_data_o,
    output logic                     rw_block_o,
    output logic                     rw_err_o,
    output logic                     axi_awvalid_o,
    input  logic                     axi_awready_i,
    output logic [RW_ADDR_WIDTH-1:0] axi_awaddr_o,
    output logic [7:0]               axi_awlen_o,
    output logic [2:0]               axi_awsize_o,
    output logic [1:0]               axi_awburst_o,
    output logic                     axi_wvalid_o,
    input  logic                     axi_wready_i,
    output logic [RW_DATA_WIDTH-1:0] axi_wdata_o,
    output logic [7:0]               axi_wstrb_o,
    output logic                     axi_wlast_o,
    input  logic                     axi_bvalid_i,
    output logic                     axi_bready_o,
    input  logic [1:0]               axi_bresp_i,
    output logic                     axi_arvalid_o,
    input  logic                     axi_arready_i,
    output logic [RW_ADDR_WIDTH-1:0] axi_araddr_o,
    output logic [7:0]               axi_arlen_o,
    output logic [2:0]               axi_arsize_o,
    output logic [1:0]               axi_arburst_o,
    output logic [2:0]               axi_arprot_o,
    input  logic                     axi_rvalid_i,
    output logic                     axi_rready_o,
    input  logic [RW_DATA_WIDTH-1:0] axi_rdata_i,
    input  logic [1:0]               axi_rresp_i,
    input  logic                     axi_rlast_i
);

    bridge_state_t            r_state;
    logic                     r_addr_ready;
    logic                     r_awvalid;
    logic                     r_arvalid;
    logic                     r_bready;
    logic                     r_err;
    logic [RW_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]               r_len;
    logic [2:0]               r_size;
    logic [1:0]               r_burst;
    logic                     r_if;
    logic [7:0]               r_cnt;

    logic       w_in_r;
    logic       w_in_w;
    logic       w_r_hs;
    logic       w_w_hs;
    logic       w_last_cnt;
    logic       w_burst;
    logic [7:0] w_wstrb;
    logic [5:0] w_wshift;
    logic [5:0] w_rshift;

    assign w_in_r     = (r_state == ST_R);
    assign w_in_w     = (r_state == ST_W);
    assign w_r_hs     = w_in_r && axi_rvalid_i && r_data_ready_i;
    assign w_w_hs     = w_in_w && w_data_valid_i && axi_wready_i;
    assign w_last_cnt = (r_cnt == 8'd0);

    // Only a single beat smaller than the bus is lane-shifted.
    assign w_burst = (r_len != 8'd0) || (r_size >= AXI_SIZE_BYTES_8);

    rw_axi4_align u_align (
        .i_off    (r_addr[2:0]),
        .i_size   (r_size),
        .i_burst  (w_burst),
        .o_wstrb  (w_wstrb),
        .o_wshift (w_wshift),
        .o_rshift (w_rshift)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr_ready <= 1'b1;
            r_awvalid    <= 1'b0;
            r_arvalid    <= 1'b0;
            r_bready     <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_if         <= 1'b0;
            r_cnt        <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (rw_addr_valid_i && r_addr_ready) begin
                        r_addr       <= rw_addr_i;
                        r_len        <= rw_len_i;
                        r_size       <= rw_size_i;
                        r_burst      <= rw_burst_i;
                        r_if         <= rw_if_i;
                        r_cnt        <= rw_len_i;
                        r_addr_ready <= 1'b0;
                        if (rw_we_i) begin
                            r_awvalid <= 1'b1;
                            r_state   <= ST_AW;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (axi_arready_i) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (w_r_hs) begin
                        r_cnt <= r_cnt - 8'd1;
                        // rlast must land exactly on the final counted beat.
                        if (is_err_resp(axi_rresp_i) ||
                            (axi_rlast_i != w_last_cnt)) begin
                            r_err <= 1'b1;
                        end
                        if (axi_rlast_i) begin
                            r_addr_ready <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                end
                ST_AW: begin
                    if (axi_awready_i) begin
                        r_awvalid <= 1'b0;
                        r_state   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_w_hs) begin
                        r_cnt <= r_cnt - 8'd1;
                        if (w_last_cnt) begin
                            r_bready <= 1'b1;
                            r_state  <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (axi_bvalid_i) begin
                        r_bready <= 1'b0;
                        if (is_err_resp(axi_bresp_i)) begin
                            r_err <= 1'b1;
                        end
                        r_addr_ready <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rw_addr_ready_o = r_addr_ready;
    assign rw_block_o      = (r_state != ST_IDLE);
    assign rw_err_o        = r_err;

    assign axi_awvalid_o = r_awvalid;
    assign axi_awaddr_o  = r_addr;
    assign axi_awlen_o   = r_len;
    assign axi_awsize_o  = r_size;
    assign axi_awburst_o = r_burst;

    assign axi_arvalid_o = r_arvalid;
    assign axi_araddr_o  = r_addr;
    assign axi_arlen_o   = r_len;
    assign axi_arsize_o  = r_size;
    assign axi_arburst_o = r_burst;
    assign axi_arprot_o  = {r_if, 2'b00};

    assign axi_wvalid_o   = w_in_w && w_data_valid_i;
    assign w_data_ready_o = w_in_w && axi_wready_i;
    assign axi_wlast_o    = w_in_w && w_last_cnt;
    assign axi_wdata_o    = w_data_i << w_wshift;
    assign axi_wstrb_o    = w_wstrb;
    assign axi_bready_o   = r_bready;

    assign r_data_valid_o = w_in_r && axi_rvalid_i;
    assign axi_rready_o   = w_in_r && r_data_ready_i;
    assign r_data_o       = axi_rdata_i >> w_rshift;

endmodule

// File: doc/rw_axi4_bridge.md
Name: rw_axi4_bridge

Overview:
Converts the simplified rw master interface into AXI4 master channels (AW/W/B/AR/R). The rw interface is the one driven by the L1 cache miss/write-back path (axi_rw_* side of the cache). It sits directly downstream of the cache and upstream of the SoC interconnect. It handles one outstanding transaction at a time: single-beat narrow accesses (uncached/MMIO) and INCR bursts (line refill/write-back).

Parameters:
RW_DATA_WIDTH, 64, rw and AXI data width (bytes per beat = 8)
RW_ADDR_WIDTH, 32, address width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rw_addr_valid_i / rw_addr_ready_o  in/out  1  request handshake
rw_addr_i  in  RW_ADDR_WIDTH  request byte address
rw_we_i  in  1  1 = write, 0 = read
rw_len_i  in  8  beats-1
rw_size_i  in  3  AXI size encoding
rw_burst_i  in  2  AXI burst type
rw_if_i  in  1  instruction fetch; drives axi_arprot_o[2]
w_data_valid_i / w_data_ready_o  in/out  1  write-beat handshake
w_data_i  in  RW_DATA_WIDTH  write data, LSB-aligned
r_data_valid_o / r_data_ready_i  out/in  1  read-beat handshake
r_data_o  out  RW_DATA_WIDTH  read data, LSB-aligned for narrow accesses
rw_block_o  out  1  transaction in flight
rw_err_o  out  1  sticky error flag
axi_awvalid_o, axi_awready_i, axi_awaddr_o, axi_awlen_o(8), axi_awsize_o(3), axi_awburst_o(2)  AW channel
axi_wvalid_o, axi_wready_i, axi_wdata_o(64), axi_wstrb_o(8), axi_wlast_o  W channel
axi_bvalid_i, axi_bready_o, axi_bresp_i(2)  B channel
axi_arvalid_o, axi_arready_i, axi_araddr_o, axi_arlen_o(8), axi_arsize_o(3), axi_arburst_o(2), axi_arprot_o(3)  AR channel
axi_rvalid_i, axi_rready_o, axi_rdata_i(64), axi_rresp_i(2), axi_rlast_i  R channel

Behaviour:
- All AXI IDs are fixed at 0 and tied off outside the bridge.
- Reset values:
  - rw_addr_ready_o = 1.
  - All AXI valid/ready outputs = 0; r_data_valid_o = 0; w_data_ready_o = 0.
  - All latched address/len/size/burst = 0.
  - rw_err_o = 0; state = IDLE.
- States: IDLE, AR, R, AW, W, B. rw_block_o = (state != IDLE).
- IDLE: on rw_addr_valid_i & rw_addr_ready_o:
  - latch addr/len/size/burst/if/we; beat counter cnt <= rw_len_i; rw_addr_ready_o <= 0.
  - If we: axi_awvalid_o <= 1, go to AW. Otherwise: axi_arvalid_o <= 1, go to AR.
  - AW/AR payload is driven from registers, stable while valid is high.
- AR: hold arvalid until axi_arready_i. On that cycle arvalid <= 0, go to R.
- R: combinational pass-through.
  - r_data_valid_o = axi_rvalid_i; axi_rready_o = r_data_ready_i.
  - Narrow single beat (len = 0, size < 3): r_data_o = rdata >> (addr[2:0]*8). Bursts pass rdata unchanged.
  - Per beat handshake: cnt <= cnt - 1.
  - On beat with axi_rlast_i: go to IDLE, rw_addr_ready_o <= 1.
  - rw_err_o is set if rresp[1] = 1, or if rlast disagrees with (cnt == 0).
  - If rlast never arrives, stay in R; no timeout.
- AW: hold awvalid until axi_awready_i. Then awvalid <= 0, go to W. W never starts before the AW handshake.
- W: combinational pass-through.
  - axi_wvalid_o = w_data_valid_i; w_data_ready_o = axi_wready_i.
  - axi_wlast_o = (cnt == 0).
  - Narrow: wdata = w_data_i << (addr[2:0]*8); wstrb = ((1 << (1 << size)) - 1) << addr[2:0], truncated to 8 bits. Burst: wstrb = 8'hff.
  - Per beat: cnt - 1. On the last-beat handshake: axi_bready_o <= 1, go to B.
- B: on axi_bvalid_i: bready <= 0, rw_err_o set if bresp[1], go to IDLE, rw_addr_ready_o <= 1.
- Latency:
  - Request to AR/AW valid: 1 cycle.
  - R/W beats: 0 added cycles.
  - Back in IDLE: next request accepted the cycle after the final handshake.
- Outside R/W, all pass-through valids/readies are forced to 0.
- rw_err_o clears only on rst.
- Reset mid-transaction: all outputs return to reset values the next cycle; the slave is not drained (system-level reset only).
- len = 255 is legal: the 8-bit counter counts down to 0 and never wraps before rlast.

Decomposition:
- Shared package (existing AXI defines file): AXI_SIZE_BYTES_1/2/4/8, AXI_BURST_TYPE_FIXED/INCR/WRAP, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, bridge state encodings.
- One sub-module: rw_axi4_align. Combinational; takes addr[2:0], size and burst flag; produces wstrb, the write shift and the read shift.

Test Plan:
- Read burst, addr 0x8000_0040, len 7, size 3, INCR:
  - AR shows araddr 0x8000_0040, arlen 7; 8 R beats forwarded unchanged.
  - rlast on beat 8 returns to IDLE; rw_err_o = 0.
- Write burst, len 7, size 3:
  - AW precedes W; wstrb = 0xff on every beat; wlast only on beat 8.
  - bresp OKAY; rw_addr_ready_o = 1 one cycle after B.
- Narrow write, addr 0x...0005, size 1, w_data_i 0xBEEF:
  - wdata = 0x00BEEF0000000000, wstrb = 0x60, wlast = 1.
- Narrow read, addr 0x...0004, size 2, rdata 0x11223344_55667788:
  - r_data_o = 0x11223344; rw_if_i = 1 gives arprot = 3'b100.
- Errors:
  - bresp SLVERR: rw_err_o rises and stays high.
  - Early rlast on beat 3 of len 7: rw_err_o set, bridge returns to IDLE.
- Backpressure and reset:
  - awready held low 5 cycles: awaddr stable, no W beat issued.
  - rst asserted in W after beat 2: next cycle all valids = 0, state IDLE.
